// File: rtl/fifo_rd_prefetch.sv
// Read-side prefetch stage: FIFO controller + sync-read RAM -> valid/ready stream.
// Define FIFO_RD_PREFETCH_REG_READY_EN for a 3-deep buffer with no m_ready->rd_rqst path.
module fifo_rd_prefetch #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  rd_rqst,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            buf_count
);

`ifdef FIFO_RD_PREFETCH_REG_READY_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif

  logic [DATA_WIDTH-1:0] buf_q [DEPTH];
  logic [DATA_WIDTH-1:0] buf_d [DEPTH];
  logic [1:0]            cnt_q;
  logic [1:0]            cnt_d;
  logic [1:0]            wr_idx;
  logic                  inflight_q;
  logic                  pop;
  logic [2:0]            occ;

  assign pop       = m_valid && m_ready;
  assign m_valid   = (cnt_q != 2'd0);
  assign m_data    = buf_q[0];
  assign buf_count = cnt_q;
  assign occ       = {1'b0, cnt_q} + {2'b0, inflight_q};

`ifdef FIFO_RD_PREFETCH_REG_READY_EN
  // Request only from registered occupancy; the extra slot covers the pop.
  assign rd_rqst = !rst && !fifo_empty && (occ < 3'(DEPTH));
`else
  // A same-cycle pop frees a slot for the data returning next cycle.
  assign rd_rqst = !rst && !fifo_empty
                && (occ < (3'(DEPTH) + {2'b0, pop}));
`endif

  // Next buffer: shift out the head on pop, then land RAM data in the first free slot.
  always_comb begin
    buf_d  = buf_q;
    wr_idx = cnt_q - {1'b0, pop};
    cnt_d  = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        buf_d[i] = buf_q[i+1];
      end
    end
    if (inflight_q) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (2'(i) == wr_idx) begin
          buf_d[i] = ram_rdata;
        end
      end
    end
  end

  // State update; reset drops buffered and in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= rd_rqst;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Occupancy plus outstanding read never exceeds the buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ <= 3'(DEPTH));
    end
  end

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Scoreboard bench for fifo_rd_prefetch with a queue-based FIFO/RAM model.
// Monitor pops expected beats; directed and random phases drive stimulus.
module tb_fifo_rd_prefetch;

`ifdef FIFO_RD_PREFETCH_REG_READY_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          rd_rqst;
  logic [DW-1:0] ram_rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    buf_count;

  fifo_rd_prefetch #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .rd_rqst(rd_rqst),
    .ram_rdata(ram_rdata), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int beats = 0;
  int nreq = 0;
  logic tb_infl = 1'b0;
  logic s_rq, s_mv, s_acc;
  logic [DW-1:0] s_md;
  logic [1:0] s_cnt;
  logic [DW-1:0] e;

  task automatic chk(input string n, input logic [DW-1:0] a,
                     input logic [DW-1:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, x);
    end
  endtask

  // Scoreboard monitor: every accepted beat must match the next FIFO entry.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected actual=%h required=none", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", m_data, e);
      end
    end
  end

  task automatic wr(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample mid-cycle, then model controller + RAM after the edge.
  task automatic cycle();
    @(negedge clk);
    s_rq  = rd_rqst;
    s_mv  = m_valid;
    s_md  = m_data;
    s_cnt = buf_count;
    s_acc = rd_rqst && !fifo_empty;
    if (s_acc) nreq++;
    if ({1'b0, buf_count} + {2'b0, tb_infl} > 3'(DEPTH))
      chk("occ_le_depth", {62'b0, buf_count}, {63'b0, tb_infl});
    @(posedge clk);
    #1;
    tb_infl = s_acc;
    if (s_acc && fifo_q.size() != 0) ram_rdata = fifo_q.pop_front();
    else ram_rdata = {$urandom, $urandom};
    fifo_empty = (fifo_q.size() == 0);
  endtask

  int n0, b0, n, guard, written;

  initial begin
    rst = 1'b1;
    fifo_empty = 1'b1;
    m_ready = 1'b0;
    ram_rdata = '0;
    repeat (3) cycle();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 0) chk("reset_m_data", s_md, 64'h0);
      chk("idle_rd_rqst", {63'b0, s_rq}, 64'h0);
      chk("idle_m_valid", {63'b0, s_mv}, 64'h0);
      chk("idle_count", {62'b0, s_cnt}, 64'h0);
    end

    // Preload 8, continuous ready
    m_ready = 1'b1;
    n0 = nreq;
    b0 = beats;
    for (int i = 1; i <= 8; i++) wr(64'(i));
    cycle();
    chk("lat_rqst_N", {63'b0, s_rq}, 64'h1);
    chk("lat_valid_N", {63'b0, s_mv}, 64'h0);
    cycle();
    chk("lat_valid_N1", {63'b0, s_mv}, 64'h0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("stream_valid", {63'b0, s_mv}, 64'h1);
    end
    cycle();
    chk("stream_rqst_end", {63'b0, s_rq}, 64'h0);
    chk("stream_nreq", 64'(nreq - n0), 64'd8);
    chk("stream_beats", 64'(beats - b0), 64'd8);

    // Backpressure
    m_ready = 1'b0;
    n0 = nreq;
    b0 = beats;
    for (int i = 1; i <= 5; i++) wr(64'(i));
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i >= 2) chk("bp_hold_data", s_md, 64'h1);
    end
    chk("bp_count", {62'b0, s_cnt}, 64'(DEPTH));
    chk("bp_nreq", 64'(nreq - n0), 64'(DEPTH));
    m_ready = 1'b1;
    repeat (12) cycle();
    chk("bp_beats", 64'(beats - b0), 64'd5);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Random traffic
    b0 = beats;
    written = 0;
    guard = 0;
    while (written < 1000 && guard < 20000) begin
      if ($urandom_range(1) == 1) begin
        wr({$urandom, $urandom});
        written++;
      end
      m_ready = ($urandom_range(1) == 1);
      cycle();
      guard++;
    end
    m_ready = 1'b1;
    repeat (30) cycle();
    chk("rand_written", 64'(written), 64'd1000);
    chk("rand_beats", 64'(beats - b0), 64'd1000);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-operation with a read outstanding
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(64'h11 + 64'(i));
    repeat (6) cycle();
    m_ready = 1'b1;
    cycle();
`ifdef FIFO_RD_PREFETCH_REG_READY_EN
    m_ready = 1'b0;
    cycle();
`endif
    chk("rst_inflight", {63'b0, tb_infl}, 64'h1);
    m_ready = 1'b0;
    rst = 1'b1;
    cycle();
    chk("rst_rqst_forced", {63'b0, s_rq}, 64'h0);
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    rst = 1'b0;
    cycle();
    chk("rst_m_valid", {63'b0, s_mv}, 64'h0);
    chk("rst_count", {62'b0, s_cnt}, 64'h0);
    chk("rst_m_data", s_md, 64'h0);
    m_ready = 1'b1;
    b0 = beats;
    for (int i = 0; i < 3; i++) wr(64'hA1 + 64'(i));
    repeat (8) cycle();
    chk("post_rst_beats", 64'(beats - b0), 64'd3);

    // Single entry while idle
    b0 = beats;
    n = 0;
    wr(64'h55);
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_rq) n++;
    end
    chk("single_rqst_pulse", 64'(n), 64'd1);
    chk("single_beats", 64'(beats - b0), 64'd1);
    chk("single_rqst_end", {63'b0, s_rq}, 64'h0);
    chk("single_count_end", {62'b0, s_cnt}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
